// File: rtl/ifu_fetch_ctrl_pkg.sv
// rtl/ifu_fetch_ctrl_pkg.sv - shared constants, queue entry type and PC range check for the fetch unit
package ifu_fetch_ctrl_pkg;

   localparam logic [31:0] PC_RESET = 32'h0000_3000;
   localparam logic [31:0] IM_BASE  = 32'h0000_3000;
   localparam int          IM_DEPTH = 4096;
   localparam int          FQ_DEPTH = 2;
   localparam int          CW       = $clog2(FQ_DEPTH + 1);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fq_entry_t;

   // True when pc is misaligned or outside [base, base + 4*depth).
   // The end bound is 33 bits wide so an IM that reaches the top of the address space still compares correctly.
   function automatic logic pc_out_of_im(input logic [31:0] pc,
                                         input logic [31:0] base,
                                         input int          depth);
      logic [32:0] im_end;
      im_end = {1'b0, base} + (33'(depth) << 2);
      return (pc[1:0] != 2'b00) | (pc < base) | ({1'b0, pc} >= im_end);
   endfunction

endpackage

// File: rtl/ifu_fetch_ctrl_if.sv
// rtl/ifu_fetch_ctrl_if.sv - IM read, redirect and decode handshake bundle of the fetch unit
interface ifu_fetch_ctrl_if;
   import ifu_fetch_ctrl_pkg::*;

   logic [31:0]   f_pc;
   logic [31:0]   f_instr;
   logic          e_redirect;
   logic [31:0]   e_target;
   logic          d_valid;
   logic [31:0]   d_instr;
   logic [31:0]   d_pc;
   logic          d_ready;
   logic          pc_fault;
   logic [CW-1:0] fq_count;

   modport master (
      output f_pc, d_valid, d_instr, d_pc, pc_fault, fq_count,
      input  f_instr, e_redirect, e_target, d_ready
   );

   modport slave (
      input  f_pc, d_valid, d_instr, d_pc, pc_fault, fq_count,
      output f_instr, e_redirect, e_target, d_ready
   );

endinterface

// File: rtl/ifu_fetch_ctrl_fetch_fifo.sv
// rtl/ifu_fetch_ctrl_fetch_fifo.sv - circular buffer of fetched {pc, instr} entries with flush
module fetch_fifo
   import ifu_fetch_ctrl_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int NW    = $clog2(DEPTH + 1)
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      push,
   input  logic      pop,
   input  logic      flush,
   input  fq_entry_t wr_data,
   output fq_entry_t rd_data,
   output logic [NW-1:0] count
);

   fq_entry_t     mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [NW-1:0] count_nxt;

   // occupancy follows push/pop; a simultaneous push and pop leaves it unchanged
   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + NW'(1);
         2'b01:   count_nxt = count - NW'(1);
         default: count_nxt = count;
      endcase
   end

   // pointers and count; DEPTH is a power of two so the pointers wrap naturally
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
      end
   end

   // entry storage; contents need no reset because the head is masked while empty
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// rtl/ifu_fetch_ctrl.sv - PC sequencer, fault detection and push/pop/redirect arbitration
module ifu_fetch_ctrl
   import ifu_fetch_ctrl_pkg::*;
(
   input logic              clk,
   input logic              reset,
   ifu_fetch_ctrl_if.master bus
);

   logic [31:0]   pc;
   logic          pc_bad;
   logic          head_valid;
   logic          push;
   logic          pop;
   logic [CW-1:0] count;
   fq_entry_t     head;
   fq_entry_t     wr_entry;

   assign pc_bad     = pc_out_of_im(pc, IM_BASE, IM_DEPTH);
   assign head_valid = (count != '0);

   // a redirect voids both the decode handshake and the fetch in the same cycle
   assign pop  = head_valid & bus.d_ready & ~bus.e_redirect;
   assign push = ~bus.e_redirect & ~pc_bad & ((count < CW'(FQ_DEPTH)) | pop);

   assign wr_entry.pc    = pc;
   assign wr_entry.instr = bus.f_instr;

   // PC register: redirect wins, otherwise advance only when the fetch was queued
   always_ff @(posedge clk or posedge reset) begin
      if (reset)               pc <= PC_RESET;
      else if (bus.e_redirect) pc <= bus.e_target;
      else if (push)           pc <= pc + 32'd4;
   end

   fetch_fifo #(.DEPTH(FQ_DEPTH)) u_fetch_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .pop     (pop),
      .flush   (bus.e_redirect),
      .wr_data (wr_entry),
      .rd_data (head),
      .count   (count)
   );

   assign bus.f_pc     = pc;
   assign bus.pc_fault = pc_bad;
   assign bus.fq_count = count;
   assign bus.d_valid  = head_valid;
   assign bus.d_pc     = head_valid ? head.pc    : '0;
   assign bus.d_instr  = head_valid ? head.instr : '0;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb/tb_ifu_fetch_ctrl.sv - directed-vector bench for ifu_fetch_ctrl
module tb_ifu_fetch_ctrl;
   import ifu_fetch_ctrl_pkg::*;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_miss;

   ifu_fetch_ctrl_if bus ();

   ifu_fetch_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   // IM model: every word holds 0xE000_0000 | its byte address
   assign bus.f_instr = 32'hE000_0000 | bus.f_pc;

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec  = 0;
      n_miss = 0;
      clk    = 1'b0;
      reset  = 1'b1;
      bus.d_ready    = 1'b0;
      bus.e_redirect = 1'b0;
      bus.e_target   = 32'h0;

      #2;
      check_eq("rst_d_valid",  32'(bus.d_valid),  32'h0);
      check_eq("rst_d_pc",     bus.d_pc,          32'h0);
      check_eq("rst_d_instr",  bus.d_instr,       32'h0);
      check_eq("rst_fq_count", 32'(bus.fq_count), 32'h0);
      check_eq("rst_f_pc",     bus.f_pc,          32'h3000);
      check_eq("rst_pc_fault", 32'(bus.pc_fault), 32'h0);

      // streaming with decode always ready
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.d_ready = 1'b1;
      tick();
      check_eq("s1_d_valid", 32'(bus.d_valid), 32'h1);
      check_eq("s1_d_pc",    bus.d_pc,         32'h3000);
      check_eq("s1_d_instr", bus.d_instr,      32'hE000_3000);
      check_eq("s1_f_pc",    bus.f_pc,         32'h3004);
      tick();
      check_eq("s2_d_pc",    bus.d_pc,         32'h3004);
      check_eq("s2_d_instr", bus.d_instr,      32'hE000_3004);
      tick();
      check_eq("s3_d_pc",    bus.d_pc,         32'h3008);
      check_eq("s3_d_instr", bus.d_instr,      32'hE000_3008);
      check_eq("s3_count",   32'(bus.fq_count), 32'h1);

      // back-pressure: queue saturates at two entries
      reset = 1'b1;
      bus.d_ready = 1'b0;
      #1;
      reset = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check_eq("bp_count", 32'(bus.fq_count), 32'h2);
      check_eq("bp_f_pc",  bus.f_pc,          32'h3008);
      check_eq("bp_d_pc",  bus.d_pc,          32'h3000);
      bus.d_ready = 1'b1;
      #1;
      check_eq("bp_rel0_d_pc", bus.d_pc, 32'h3000);
      tick();
      check_eq("bp_rel1_d_pc",  bus.d_pc,          32'h3004);
      check_eq("bp_rel1_count", 32'(bus.fq_count), 32'h2);
      check_eq("bp_rel1_f_pc",  bus.f_pc,          32'h300C);
      tick();
      check_eq("bp_rel2_d_pc",  bus.d_pc,          32'h3008);

      // redirect while full, with decode ready in the same cycle
      bus.d_ready = 1'b0;
      tick();
      check_eq("full_count", 32'(bus.fq_count), 32'h2);
      check_eq("full_f_pc",  bus.f_pc,          32'h3010);
      bus.e_redirect = 1'b1;
      bus.e_target   = 32'h3100;
      bus.d_ready    = 1'b1;
      tick();
      check_eq("rd_count",   32'(bus.fq_count), 32'h0);
      check_eq("rd_d_valid", 32'(bus.d_valid),  32'h0);
      check_eq("rd_f_pc",    bus.f_pc,          32'h3100);
      bus.e_redirect = 1'b0;
      tick();
      check_eq("rd_d_pc",    bus.d_pc,          32'h3100);
      check_eq("rd_d_instr", bus.d_instr,       32'hE000_3100);

      // misaligned redirect target
      bus.e_redirect = 1'b1;
      bus.e_target   = 32'h3102;
      tick();
      check_eq("mis_fault", 32'(bus.pc_fault), 32'h1);
      check_eq("mis_f_pc",  bus.f_pc,          32'h3102);
      bus.e_redirect = 1'b0;
      tick();
      tick();
      check_eq("mis_d_valid", 32'(bus.d_valid),  32'h0);
      check_eq("mis_count",   32'(bus.fq_count), 32'h0);
      check_eq("mis_hold_pc", bus.f_pc,          32'h3102);
      bus.e_redirect = 1'b1;
      bus.e_target   = 32'h3010;
      tick();
      check_eq("rec_fault", 32'(bus.pc_fault), 32'h0);
      check_eq("rec_f_pc",  bus.f_pc,          32'h3010);
      bus.e_redirect = 1'b0;
      tick();
      check_eq("rec_d_valid", 32'(bus.d_valid), 32'h1);
      check_eq("rec_d_pc",    bus.d_pc,         32'h3010);

      // last IM word, then fetch stops at the end of IM
      bus.e_redirect = 1'b1;
      bus.e_target   = 32'h6FFC;
      tick();
      check_eq("end_f_pc0",  bus.f_pc,          32'h6FFC);
      check_eq("end_fault0", 32'(bus.pc_fault), 32'h0);
      bus.e_redirect = 1'b0;
      tick();
      check_eq("end_d_pc",   bus.d_pc,          32'h6FFC);
      check_eq("end_f_pc1",  bus.f_pc,          32'h7000);
      check_eq("end_fault1", 32'(bus.pc_fault), 32'h1);
      check_eq("end_count1", 32'(bus.fq_count), 32'h1);
      tick();
      tick();
      check_eq("end_d_valid", 32'(bus.d_valid),  32'h0);
      check_eq("end_count2",  32'(bus.fq_count), 32'h0);
      check_eq("end_f_pc2",   bus.f_pc,          32'h7000);

      // asynchronous reset with two entries queued
      bus.e_redirect = 1'b1;
      bus.e_target   = 32'h3020;
      bus.d_ready    = 1'b0;
      tick();
      bus.e_redirect = 1'b0;
      tick();
      tick();
      check_eq("pre_rst_count", 32'(bus.fq_count), 32'h2);
      check_eq("pre_rst_d_pc",  bus.d_pc,          32'h3020);
      check_eq("pre_rst_f_pc",  bus.f_pc,          32'h3028);
      #2;
      reset = 1'b1;
      #1;
      check_eq("arst_d_valid", 32'(bus.d_valid),  32'h0);
      check_eq("arst_count",   32'(bus.fq_count), 32'h0);
      check_eq("arst_f_pc",    bus.f_pc,          32'h3000);
      check_eq("arst_d_pc",    bus.d_pc,          32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.d_ready = 1'b1;
      tick();
      check_eq("post_rst_d_pc", bus.d_pc, 32'h3000);
      check_eq("post_rst_f_pc", bus.f_pc, 32'h3004);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
